if_fetch_unit: RTL

- Instruction-fetch stage feeding the IF/ID pipeline register.
- Generates the PC and issues single-outstanding requests to instruction memory.
- Buffers returned instructions against downstream stalls and applies branch redirects and flushes.
- Outputs o_code/o_pc connect directly to the IF/ID register's i_code/i_pc; the hazard unit's is_stop is shared by both blocks.

---
 rtl/if_fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, single-outstanding imem requests,
// output + skid buffering against stalls, redirect/flush. Optional counters: IF_FETCH_PERF_EN.
module if_fetch_unit #(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0,
   parameter int unsigned            PC_STEP    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  is_stop,
   input  logic                  br_taken,
   input  logic [DATA_WIDTH-1:0] br_target,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_valid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_code,
   output logic [DATA_WIDTH-1:0] o_pc
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt,
   output logic [31:0]           perf_kill_cnt
`endif
);

   typedef enum logic [1:0] {REQ, WAIT, FULL} state_t;

   state_t                state_q, state_d;
   logic                  kill_q, kill_d;
   logic [DATA_WIDTH-1:0] pc_q, req_pc;
   logic                  sk_valid;
   logic [DATA_WIDTH-1:0] sk_code, sk_pc;

   logic consume, issue, load_rsp, load_sk, sk_move, drop;

   assign consume   = o_valid & ~is_stop;
   assign imem_addr = pc_q;
   // rst is folded in so nothing is requested while reset is held.
   assign issue     = rst & (state_q == REQ) & ~br_taken;
   assign imem_req  = issue;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= REQ;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      kill_d   = kill_q;
      load_rsp = 1'b0;
      load_sk  = 1'b0;
      sk_move  = 1'b0;
      drop     = 1'b0;
      if (br_taken) begin
         state_d = REQ;
         if (state_q == WAIT) begin
            if (imem_valid) begin
               drop   = 1'b1;
               kill_d = 1'b0;
            end else begin
               // response still in flight: remember to discard it
               kill_d  = 1'b1;
               state_d = WAIT;
            end
         end
      end else begin
         case (state_q)
            REQ:  state_d = WAIT;
            WAIT: begin
               if (imem_valid) begin
                  state_d = REQ;
                  if (kill_q) begin
                     drop   = 1'b1;
                     kill_d = 1'b0;
                  end else if (!o_valid || consume) begin
                     load_rsp = 1'b1;
                  end else begin
                     load_sk = 1'b1;
                     state_d = FULL;
                  end
               end
            end
            FULL: begin
               if (consume) begin
                  sk_move = 1'b1;
                  state_d = REQ;
               end
            end
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_PC;
         req_pc <= '0;
      end else if (br_taken) begin
         pc_q <= br_target;
      end else if (issue) begin
         req_pc <= pc_q;
         pc_q   <= pc_q + DATA_WIDTH'(PC_STEP);
      end
   end

   // Output buffer: a word not replaced on consume leaves a NOP bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_valid <= 1'b0;
         o_code  <= '0;
         o_pc    <= '0;
      end else if (br_taken) begin
         o_valid <= 1'b0;
         o_code  <= '0;
         o_pc    <= '0;
      end else if (load_rsp) begin
         o_valid <= 1'b1;
         o_code  <= imem_rdata;
         o_pc    <= req_pc;
      end else if (sk_move) begin
         o_valid <= 1'b1;
         o_code  <= sk_code;
         o_pc    <= sk_pc;
      end else if (consume) begin
         o_valid <= 1'b0;
         o_code  <= '0;
         o_pc    <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sk_valid <= 1'b0;
         sk_code  <= '0;
         sk_pc    <= '0;
      end else if (br_taken) begin
         sk_valid <= 1'b0;
      end else if (load_sk) begin
         sk_valid <= 1'b1;
         sk_code  <= imem_rdata;
         sk_pc    <= req_pc;
      end else if (sk_move) begin
         sk_valid <= 1'b0;
      end
   end

`ifdef IF_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (o_valid && is_stop && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (drop && perf_kill_cnt != 32'hFFFF_FFFF)
            perf_kill_cnt <= perf_kill_cnt + 32'd1;
      end
   end
`endif

endmodule
